// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: DATA_BITS/PARITY/STOP_BITS framing, 3-sample majority vote per bit.
// Define UART_RX_CFG_BREAK_EN to add break detection (break_det port, BREAK_WAIT state).
module uart_rx_cfg #(
  parameter int CLK_FREQ  = 12_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
`ifdef UART_RX_CFG_BREAK_EN
  ,
  output logic                 break_det
`endif
);
  localparam int CPB  = CLK_FREQ / BAUD_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);

  if (CPB < 8) begin : g_cpb_chk
    $error("uart_rx_cfg: CLK_FREQ/BAUD_RATE must be at least 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_db_chk
    $error("uart_rx_cfg: DATA_BITS must be 5..9");
  end

`ifdef UART_RX_CFG_BREAK_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BREAK_WAIT} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
`endif

  state_t                 state, state_d;
  logic [1:0]             sync;
  logic                   rs;
  logic [CW-1:0]          cnt;
  logic [1:0]             samp;
  logic [3:0]             bidx;
  logic [DATA_BITS-1:0]   sh;
  logic                   ferr_acc, perr_acc;
  logic                   maj, dec, fin;
`ifdef UART_RX_CFG_BREAK_EN
  logic                   allz, brk;
`endif

  assign rs   = sync[1];
  assign busy = (state != IDLE);
  assign maj  = (samp[0] & samp[1]) | (samp[0] & rs) | (samp[1] & rs);
  // Decision point is T_k+1: the third sample is rs itself this cycle.
  assign dec  = (state == START || state == DATA || state == PAR || state == STOP) &&
                (cnt == CW'(HALF));

  always_comb begin
    state_d = state;
    fin     = 1'b0;
`ifdef UART_RX_CFG_BREAK_EN
    brk     = 1'b0;
`endif
    case (state)
      IDLE:  if (!rs) state_d = START;
      START: if (dec) state_d = maj ? IDLE : DATA;
      DATA:  if (dec && bidx == 4'(DATA_BITS-1)) state_d = (PARITY != 0) ? PAR : STOP;
      PAR:   if (dec) state_d = STOP;
      STOP: begin
        if (dec && bidx == 4'(STOP_BITS-1)) begin
          fin     = 1'b1;
          state_d = IDLE;
`ifdef UART_RX_CFG_BREAK_EN
          brk = allz & ~maj;
          if (brk) state_d = BREAK_WAIT;
`endif
        end
      end
`ifdef UART_RX_CFG_BREAK_EN
      BREAK_WAIT: if (rs && cnt == CW'(CPB-1)) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      sync       <= 2'b11;
      cnt        <= '0;
      samp       <= '0;
      bidx       <= '0;
      sh         <= '0;
      ferr_acc   <= 1'b0;
      perr_acc   <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
`ifdef UART_RX_CFG_BREAK_EN
      allz       <= 1'b0;
      break_det  <= 1'b0;
`endif
    end else begin
      state <= state_d;
      sync  <= {sync[0], rx};
      valid <= 1'b0;
`ifdef UART_RX_CFG_BREAK_EN
      break_det <= 1'b0;
      if (state == BREAK_WAIT) cnt <= rs ? cnt + 1'b1 : '0;
      else
`endif
      if (state == IDLE || state_d == IDLE) cnt <= '0;
      else cnt <= (cnt == CW'(CPB-1)) ? '0 : cnt + 1'b1;

      if (cnt == CW'(HALF-2)) samp[0] <= rs;
      if (cnt == CW'(HALF-1)) samp[1] <= rs;

      case (state)
        START: begin
          bidx     <= '0;
          ferr_acc <= 1'b0;
          perr_acc <= 1'b0;
`ifdef UART_RX_CFG_BREAK_EN
          allz     <= 1'b1;
`endif
        end
        DATA: if (dec) begin
          sh   <= {maj, sh[DATA_BITS-1:1]};
          bidx <= (bidx == 4'(DATA_BITS-1)) ? '0 : bidx + 1'b1;
        end
        PAR: if (dec)
          perr_acc <= (PARITY == 1) ? ~(^sh ^ maj) : (^sh ^ maj);
        STOP: if (dec) begin
          bidx <= bidx + 1'b1;
          if (!maj) ferr_acc <= 1'b1;
        end
        default: ;
      endcase
`ifdef UART_RX_CFG_BREAK_EN
      if (dec && state != START && maj) allz <= 1'b0;
`endif

      if (fin) begin
        valid      <= 1'b1;
        data       <= sh;
        frame_err  <= ferr_acc | ~maj;
        parity_err <= perr_acc;
`ifdef UART_RX_CFG_BREAK_EN
        break_det  <= brk;
`endif
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: an 8N1 instance and a 7E2 instance driven by bench-built frames.
module tb_uart_rx_cfg;
  localparam int CPB = 104;

  logic clk = 1'b0;
  logic rst0, rst1, rx0, rx1;
  logic [7:0] data0;
  logic [6:0] data1;
  logic valid0, fe0, pe0, busy0, valid1, fe1, pe1, busy1;
`ifdef UART_RX_CFG_BREAK_EN
  logic brk0, brk1;
`endif

  int checks = 0, errors = 0;
  int vcnt0 = 0, vcnt1 = 0, wide0 = 0, wide1 = 0, bcnt0 = 0;
  int cyc = 0, t_last0 = 0, t_prev0 = 0;
  logic pv0 = 1'b0, pv1 = 1'b0;
  int ev0 = 0, ev1 = 0;

  always #5 clk = ~clk;

  uart_rx_cfg u0 (
    .clk(clk), .rst_n(rst0), .rx(rx0), .data(data0), .valid(valid0),
    .frame_err(fe0), .parity_err(pe0), .busy(busy0)
`ifdef UART_RX_CFG_BREAK_EN
    , .break_det(brk0)
`endif
  );

  uart_rx_cfg #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u1 (
    .clk(clk), .rst_n(rst1), .rx(rx1), .data(data1), .valid(valid1),
    .frame_err(fe1), .parity_err(pe1), .busy(busy1)
`ifdef UART_RX_CFG_BREAK_EN
    , .break_det(brk1)
`endif
  );

  always @(negedge clk) begin
    cyc++;
    if (valid0) begin
      vcnt0++;
      t_prev0 = t_last0;
      t_last0 = cyc;
      if (pv0) wide0++;
`ifdef UART_RX_CFG_BREAK_EN
      if (brk0) bcnt0++;
`endif
    end
    if (valid1) begin
      vcnt1++;
      if (pv1) wide1++;
    end
    pv0 = valid0;
    pv1 = valid1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Drives n frame bits LSB first; gcyc flips rx for one cycle, rcyc pulses u0 reset.
  task automatic send(input int which, input logic [15:0] bits, input int n,
                      input int gcyc, input int rcyc);
    logic b;
    int   a;
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        a = i * CPB + c;
        b = bits[i];
        if (a == gcyc) b = ~b;
        if (which == 0) begin
          rx0  = b;
          rst0 = (a == rcyc) ? 1'b0 : 1'b1;
        end else rx1 = b;
      end
    end
    @(negedge clk);
    rx0  = 1'b1;
    rx1  = 1'b1;
    rst0 = 1'b1;
  endtask

  function automatic logic [15:0] f8(input logic [7:0] d, input logic stop);
    return {6'b0, stop, d, 1'b0};
  endfunction

  function automatic logic [15:0] f7e2(input logic [6:0] d, input logic p);
    return {5'b0, 2'b11, p, d, 1'b0};
  endfunction

  initial begin
    logic [7:0] bytes [5];
    int gap;
    bytes[0] = 8'h55; bytes[1] = 8'hAA; bytes[2] = 8'h00; bytes[3] = 8'hFF; bytes[4] = 8'hC3;
    rst0 = 1'b0; rst1 = 1'b0; rx0 = 1'b1; rx1 = 1'b1;
    idle(5);
    chk("rst_data0", {24'b0, data0}, 0);
    chk("rst_flags0", {valid0, fe0, pe0, busy0}, 0);
    chk("rst_flags1", {data1, valid1, fe1, pe1, busy1}, 0);
    rst0 = 1'b1; rst1 = 1'b1;
    idle(20);

    for (int i = 0; i < 5; i++) begin
      send(0, f8(bytes[i], 1'b1), 10, -1, -1);
      ev0++;
      chk("8n1_cnt", vcnt0, ev0);
      chk("8n1_data", {24'b0, data0}, {24'b0, bytes[i]});
      chk("8n1_err", {fe0, pe0}, 0);
      idle(30);
    end
    chk("8n1_width", wide0, 0);

    // 0x5A has four ones, so even parity bit is 0.
    send(1, f7e2(7'h5A, 1'b0), 11, -1, -1);
    ev1++;
    chk("7e2_cnt", vcnt1, ev1);
    chk("7e2_data", {25'b0, data1}, 32'h5A);
    chk("7e2_err", {fe1, pe1}, 0);
    idle(50);
    send(1, f7e2(7'h5A, 1'b1), 11, -1, -1);
    ev1++;
    chk("7e2_bad_cnt", vcnt1, ev1);
    chk("7e2_bad_perr", {fe1, pe1}, 32'h1);
    chk("7e2_width", wide1, 0);
    idle(50);

    send(0, f8(8'h3C, 1'b0), 10, -1, -1);
    ev0++;
    chk("stop_cnt", vcnt0, ev0);
    chk("stop_data", {24'b0, data0}, 32'h3C);
    chk("stop_ferr", fe0, 1);
    idle(200);
    chk("stop_nospur", vcnt0, ev0);
    send(0, f8(8'h01, 1'b1), 10, -1, -1);
    ev0++;
    chk("after_cnt", vcnt0, ev0);
    chk("after_data", {24'b0, data0}, 32'h01);
    chk("after_ferr", fe0, 0);
    idle(50);

    rx0 = 1'b0;
    idle(30);
    rx0 = 1'b1;
    idle(30);
    chk("glitch_busy", busy0, 0);
    chk("glitch_cnt", vcnt0, ev0);
    idle(50);

    send(0, f8(8'h80, 1'b1), 10, 4 * CPB + 52, -1);
    ev0++;
    chk("maj_cnt", vcnt0, ev0);
    chk("maj_data", {24'b0, data0}, 32'h80);
    idle(50);

    // Bits after the reset are all 1, so nothing can resynchronise onto the tail.
    send(0, f8(8'hF0, 1'b1), 10, -1, 5 * CPB + 50);
    chk("mrst_cnt", vcnt0, ev0);
    chk("mrst_out", {data0, valid0, fe0, pe0, busy0}, 0);
    idle(200);
    send(0, f8(8'h69, 1'b1), 10, -1, -1);
    ev0++;
    chk("post_rst_cnt", vcnt0, ev0);
    chk("post_rst_data", {24'b0, data0}, 32'h69);
    idle(50);

    send(0, f8(8'h48, 1'b1), 10, -1, -1);
    chk("b2b_first", {24'b0, data0}, 32'h48);
    send(0, f8(8'h69, 1'b1), 10, -1, -1);
    ev0 += 2;
    chk("b2b_cnt", vcnt0, ev0);
    chk("b2b_second", {24'b0, data0}, 32'h69);
    gap = t_last0 - t_prev0;
    chk("b2b_gap", (gap >= 1038 && gap <= 1042), 1);
    idle(50);

`ifdef UART_RX_CFG_BREAK_EN
    rx0 = 1'b0;
    idle(3000);
    rx0 = 1'b1;
    idle(100);
    chk("brk_busy_hi", busy0, 1);
    idle(20);
    chk("brk_busy_lo", busy0, 0);
    idle(300);
    ev0++;
    chk("brk_cnt", vcnt0, ev0);
    chk("brk_det", bcnt0, 1);
    chk("brk_ferr", {fe0, data0}, 32'h100);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
